display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexes a single shared 7-segment decoder across NUM_DIGITS common-anode digits for the stopwatch display. It latches a BCD display word through a load handshake and commits it only at frame boundaries, so digits never tear. It then scans the digits with a blanking gap between slots to prevent ghosting. It sits between the stopwatch counter logic, which supplies the BCD digits, and the board's HEX segment/anode pins. The decoder itself stays external and combinational.

## Interface
- NUM_DIGITS, 4: number of scanned digits (≥2).
- SLOT_CYCLES, 50000: clock cycles per digit slot.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < SLOT_CYCLES.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  scan enable; 0 forces display dark.
- load  in  1  one-cycle strobe: capture digits_in/lz_suppress into shadow.
- digits_in  in  4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (rightmost).
- lz_suppress  in  1  leading-zero suppression for the loaded word.
- load_ack  out  1  one-cycle pulse when the shadow word is committed to the active word.
- dec_digit  out  4  BCD value driven to the shared decoder input.
- dec_display  in  7  decoder output (active-low segments), combinational from dec_digit.
- seg_n  out  7  registered segment drive, active-low.
- an_n  out  NUM_DIGITS  registered anode drive, one-cold, active-low.

## Operation
- Registers: shadow word plus shadow lz, a pending flag, active word plus active lz, slot counter, digit index, and a state machine.
- Load: when load=1, the shadow takes digits_in/lz_suppress and pending is set. A load while pending is set overwrites the shadow (last load wins).
- Commit: occurs on entry to the BLANK state for digit 0 (frame boundary) while pending=1. At that point active ← shadow, pending is cleared, and load_ack=1 for that cycle. A load in the same cycle as a commit goes to the shadow and pending stays set.
- States:
  - IDLE: an_n all 1, seg_n=7'h7F.
  - BLANK: an_n all 1, seg_n=7'h7F, dec_digit = the active digit at the current index.
  - DRIVE: anode for the current index low; seg_n = dec_display, or 7'h7F if the digit is suppressed.
- Transitions:
  - IDLE→BLANK(digit 0) when enable=1.
  - BLANK→DRIVE after BLANK_CYCLES cycles.
  - DRIVE→BLANK(next index) when the slot count reaches SLOT_CYCLES. The index wraps NUM_DIGITS−1→0.
  - Any state→IDLE on the cycle after enable=0.
- Suppression: with active lz=1, digit k (k≥1) is suppressed if it is 0 and all digits above k are 0. Digit 0 is never suppressed. A suppressed digit keeps its anode high for its whole slot, and its slot timing is unchanged.
- Digit values >9 pass through to the decoder unmodified.
- Reset values: state IDLE, seg_n=7'h7F, an_n all 1, dec_digit=0, load_ack=0, active/shadow words 0, both lz flags 0, pending=0, counters 0.

## Timing
- dec_digit is registered when entering BLANK and is stable for the whole slot. The decoder therefore has BLANK_CYCLES cycles to settle before seg_n samples it.
- seg_n and an_n change together on the BLANK→DRIVE edge and return to dark together on the DRIVE→BLANK edge.
- Slot length is exactly SLOT_CYCLES: BLANK_CYCLES dark cycles, then SLOT_CYCLES−BLANK_CYCLES lit cycles. Frame length is NUM_DIGITS×SLOT_CYCLES.
- Load-to-display latency: from 1 up to one frame plus BLANK_CYCLES. The active word never changes mid-frame.
- Enable low mid-slot: outputs go dark the next cycle and counters are cleared. Re-enabling always restarts at digit 0, which commits any pending word.
- Reset mid-operation: all state and outputs return to reset values on the next edge, and any pending load is discarded.

## Test plan
- Use NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, with a reference decoder model.
- Reset: hold reset_n=0 for 3 cycles with enable=1 and load=1 → seg_n=7F, an_n=4'b1111, load_ack=0. Release, with no load → digit 0 shows decoded 0.
- Scan order: load 16'h1234, enable=1 → load_ack pulses once at the frame start. an_n cycles 1110,1101,1011,0111, each low for 6 cycles after 2 dark cycles. seg_n shows decode(4),(3),(2),(1).
- Suppression: load 16'h0070 with lz=1 → digits 3 and 2 stay dark, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 with lz=1 → only digit 0 is lit, showing 0.
- Tear-free load: load 16'h5678 during the digit-2 DRIVE of frame 16'h1234 → digit 3 still shows 1. Digit 0 of the next frame shows 8, and load_ack fires on that frame's first BLANK cycle. A second load 16'h9999 before the frame boundary → 16'h9999 wins, with one load_ack.
- Enable drop: deassert enable mid digit-1 DRIVE → next cycle an_n=1111, seg_n=7F. Reassert → 2 dark cycles, then digit 0 lit.
- Mid-operation reset: assert reset_n=0 during DRIVE with a load pending → outputs go dark next edge. After release and enable, digit 0 shows decoded 0 and no load_ack occurs.

Source files
------------

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller: latches a BCD word via a load strobe,
// commits it at frame boundaries and scans the digits with a dark gap per slot.
module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      lz_suppress,
    output logic                      load_ack,
    output logic [3:0]                dec_digit,
    input  logic [6:0]                dec_display,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic [1:0]                dbg_state
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_DARK   = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    shadow_lz_q, shadow_lz_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    active_lz_q, active_lz_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [3:0]              dec_digit_q, dec_digit_d;
    logic                    load_ack_q, load_ack_d;

    logic [NUM_DIGITS-1:0]   supp;
    logic                    all_zero;
    logic                    enter_blank;
    logic                    commit;
    logic [IW-1:0]           next_idx;
    logic [4*NUM_DIGITS-1:0] word_sel;
    logic [NUM_DIGITS-1:0]   an_lit;
    logic [6:0]              seg_lit;

    // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (active_q[4*k +: 4] == 4'd0);
            supp[k]  = active_lz_q & all_zero;
        end
    end

    always_comb begin
        an_lit  = supp[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_lit = supp[idx_q] ? SEG_DARK : dec_display;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        shadow_lz_d = shadow_lz_q;
        pending_d   = pending_q;
        active_d    = active_q;
        active_lz_d = active_lz_q;
        seg_n_d     = SEG_DARK;
        an_n_d      = '1;
        dec_digit_d = dec_digit_q;
        load_ack_d  = 1'b0;
        enter_blank = 1'b0;
        commit      = 1'b0;
        next_idx    = idx_q;
        word_sel    = active_q;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_BLANK;
                    cnt_d       = '0;
                    next_idx    = '0;
                    enter_blank = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        an_n_d  = an_lit;
                        seg_n_d = seg_lit;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d     = S_BLANK;
                        cnt_d       = '0;
                        next_idx    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        enter_blank = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        an_n_d  = an_lit;
                        seg_n_d = seg_lit;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // Frame boundary: the committed word is used for the digit-0 decoder value.
        if (enter_blank) begin
            idx_d  = next_idx;
            commit = pending_q && (next_idx == '0);
            if (commit) begin
                active_d    = shadow_q;
                active_lz_d = shadow_lz_q;
                pending_d   = 1'b0;
                load_ack_d  = 1'b1;
                word_sel    = shadow_q;
            end
            dec_digit_d = word_sel[{next_idx, 2'b00} +: 4];
        end

        if (load) begin
            shadow_d    = digits_in;
            shadow_lz_d = lz_suppress;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_lz_q <= 1'b0;
            pending_q   <= 1'b0;
            active_q    <= '0;
            active_lz_q <= 1'b0;
            seg_n_q     <= SEG_DARK;
            an_n_q      <= '1;
            dec_digit_q <= 4'd0;
            load_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_lz_q <= shadow_lz_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            active_lz_q <= active_lz_d;
            seg_n_q     <= seg_n_d;
            an_n_q      <= an_n_d;
            dec_digit_q <= dec_digit_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign seg_n     = seg_n_q;
    assign an_n      = an_n_q;
    assign dec_digit = dec_digit_q;
    assign load_ack  = load_ack_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: frame-position model checked every cycle,
// plus directed scenarios with hand-computed segment/anode values.
module tb_display_scan_controller;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b1;
    logic [15:0] digits_in = 16'hFFFF;
    logic        lz_suppress = 1'b0;
    logic        load_ack;
    logic [3:0]  dec_digit;
    logic [6:0]  dec_display;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    // Reference external decoder, active-low gfedcba
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    assign dec_display = seg7(dec_digit);

    always #5 clk = ~clk;

    display_scan_controller #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .digits_in(digits_in), .lz_suppress(lz_suppress), .load_ack(load_ack),
        .dec_digit(dec_digit), .dec_display(dec_display), .seg_n(seg_n),
        .an_n(an_n), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scanning flag, cycle position in the frame, shadow/active words
    bit          m_started = 0;
    bit          m_scan = 0;
    int          m_pos = 0;
    logic [15:0] m_active = '0, m_shadow = '0;
    bit          m_alz = 0, m_slz = 0, m_pending = 0, m_ack = 0;

    always @(posedge clk) begin
        m_started = 1;
        m_ack = 0;
        if (!reset_n) begin
            m_scan = 0; m_pos = 0; m_active = '0; m_shadow = '0;
            m_alz = 0; m_slz = 0; m_pending = 0;
        end else begin
            bit frame_start;
            frame_start = 0;
            if (!enable) begin
                m_scan = 0; m_pos = 0;
            end else if (!m_scan) begin
                m_scan = 1; m_pos = 0; frame_start = 1;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                frame_start = (m_pos == 0);
            end
            if (frame_start && m_pending) begin
                m_active = m_shadow; m_alz = m_slz; m_pending = 0; m_ack = 1;
            end
            if (load) begin
                m_shadow = digits_in; m_slz = lz_suppress; m_pending = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic [3:0] e_dig;
            int dig;
            e_an = 4'hF; e_seg = 7'h7F; e_dig = 4'h0; dig = 0;
            if (m_scan) begin
                dig   = m_pos / SLOT;
                e_dig = 4'((m_active >> (4 * dig)) & 16'hF);
                if ((m_pos % SLOT) >= BLANK &&
                    !(m_alz && dig >= 1 && (m_active >> (4 * dig)) == 16'h0)) begin
                    e_an  = ~(4'b0001 << dig);
                    e_seg = seg7(e_dig);
                end
                check("model_dec_digit", dec_digit, e_dig);
            end
            check("model_an_n", an_n, e_an);
            check("model_seg_n", seg_n, e_seg);
            check("model_load_ack", load_ack, m_ack);
            if (load_ack) ack_cnt++;
        end
    end

    task automatic drive_load(input logic [15:0] d, input logic lz);
        @(posedge clk); #1;
        load = 1'b1; digits_in = d; lz_suppress = lz;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_an(input string name, input logic [3:0] pat, input logic [6:0] exp_seg);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an_n == pat) break;
        end
        check({name, "_an"}, an_n, pat);
        check({name, "_seg"}, seg_n, exp_seg);
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (load_ack) break;
        end
        check(name, load_ack, 1'b1);
    endtask

    initial begin
        int snap, dark, mask;

        // Reset held with enable and load asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an_n, 4'hF);
        check("rst_seg", seg_n, 7'h7F);
        check("rst_ack", load_ack, 1'b0);
        check("rst_dec", dec_digit, 4'h0);
        reset_n = 1'b1; load = 1'b0;
        wait_an("rst_d0", 4'b1110, 7'h40);

        // Scan order with 1234
        @(posedge clk); #1; enable = 1'b0;
        repeat (2) @(posedge clk);
        drive_load(16'h1234, 1'b0);
        snap = ack_cnt;
        enable = 1'b1;
        wait_an("scan_d0", 4'b1110, 7'h19);
        wait_an("scan_d1", 4'b1101, 7'h30);
        wait_an("scan_d2", 4'b1011, 7'h24);
        wait_an("scan_d3", 4'b0111, 7'h79);
        @(posedge clk); #1;
        check("scan_one_ack", ack_cnt - snap, 1);

        // Tear-free load during digit-2 drive
        wait_an("tear_d2", 4'b1011, 7'h24);
        drive_load(16'h5678, 1'b0);
        wait_an("tear_d3_old", 4'b0111, 7'h79);
        wait_ack("tear_ack");
        check("tear_ack_dark", an_n, 4'hF);
        check("tear_ack_dec", dec_digit, 4'h8);
        wait_an("tear_d0_new", 4'b1110, 7'h00);
        wait_an("tear_d1_new", 4'b1101, 7'h78);
        drive_load(16'h1111, 1'b0);
        drive_load(16'h9999, 1'b0);
        snap = ack_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("last_load_one_ack", ack_cnt - snap, 1);
        wait_an("last_load_d0", 4'b1110, 7'h10);

        // Enable drop mid digit-1 drive
        wait_an("en_d1", 4'b1101, 7'h10);
        @(posedge clk); #1; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_off_an", an_n, 4'hF);
        check("en_off_seg", seg_n, 7'h7F);
        @(posedge clk); #1; enable = 1'b1;
        @(posedge clk);
        dark = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an_n != 4'hF) break;
            dark++;
        end
        check("en_dark_cycles", dark, 2);
        check("en_restart_an", an_n, 4'b1110);
        check("en_restart_seg", seg_n, 7'h10);

        // Leading-zero suppression
        drive_load(16'h0070, 1'b1);
        wait_ack("lz_ack1");
        mask = 0;
        repeat (FRAME) begin
            @(negedge clk);
            mask = mask | int'(~an_n & 4'hF);
        end
        check("lz_mask_0070", mask, 4'b0011);
        wait_an("lz_d0", 4'b1110, 7'h40);
        wait_an("lz_d1", 4'b1101, 7'h78);
        drive_load(16'h0000, 1'b1);
        wait_ack("lz_ack2");
        mask = 0;
        repeat (FRAME) begin
            @(negedge clk);
            mask = mask | int'(~an_n & 4'hF);
        end
        check("lz_mask_0000", mask, 4'b0001);

        // Mid-operation reset with a pending load
        wait_an("mr_d0", 4'b1110, 7'h40);
        drive_load(16'h4321, 1'b0);
        @(posedge clk); #1; reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mr_an", an_n, 4'hF);
        check("mr_seg", seg_n, 7'h7F);
        @(posedge clk); #1; reset_n = 1'b1;
        snap = ack_cnt;
        wait_an("mr_d0_after", 4'b1110, 7'h40);
        check("mr_dec", dec_digit, 4'h0);
        repeat (2 * FRAME) @(posedge clk);
        #1;
        check("mr_no_ack", ack_cnt - snap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
